// File: rtl/mem_port.sv
// mem_port: parametrised data-memory port with byte-lane writes, registered read
// latency, two-beat handling of word-crossing accesses, busy back-pressure and
// an out-of-range error pulse.
module mem_port #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              resetn,      // active-high despite the name
    input  logic [XLEN-1:0]   mem_addr,
    input  logic              mem_r,
    input  logic [XLEN/8-1:0] mem_w,
    input  logic [XLEN-1:0]   mem_din,
    output logic [XLEN-1:0]   mem_dout,
    output logic              mem_rvalid,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int unsigned BYTES   = XLEN / 8;
    localparam int unsigned OFFW    = $clog2(BYTES);
    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned LIMIT_B = DEPTH_WORDS * BYTES;

    typedef enum logic {StIdle, StSplit} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    // Request decode
    logic              req, accept, conflict, oor, split, split_go;
    logic [OFFW-1:0]   off, hi_lane;
    logic [AW-1:0]     word_idx;
    logic [XLEN:0]     last_byte;
    logic [2*XLEN-1:0] wdata_sh;
    logic [2*BYTES-1:0] wstrb_sh;
    logic [XLEN-1:0]   rd_word, hi_word, split_rdata;

    // Second-beat context captured when a split access is accepted
    logic [AW-1:0]     hold_word_q;
    logic [XLEN-1:0]   hold_wdata_q;
    logic [BYTES-1:0]  hold_wstrb_q;
    logic [XLEN-1:0]   hold_rdata_q;
    logic [OFFW-1:0]   hold_off_q;
    logic              hold_is_read_q;
    logic              hold_err_q;

    // Array write port
    logic [BYTES-1:0]  wr_en;
    logic [AW-1:0]     wr_idx;
    logic [XLEN-1:0]   wr_data;

    // Read pipeline
    logic              push_valid;
    logic [XLEN-1:0]   push_data;
    logic              pipe_valid_q [READ_LAT];
    logic [XLEN-1:0]   pipe_data_q  [READ_LAT];
    logic              err_q;

    assign off      = mem_addr[OFFW-1:0];
    assign word_idx = mem_addr[OFFW +: AW];
    assign rd_word  = mem_q[word_idx];
    assign hi_word  = mem_q[hold_word_q];

    // Classify the incoming request: acceptance, range, word crossing
    always_comb begin
        hi_lane = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (mem_w[i]) hi_lane = OFFW'(i);
        end
        if (mem_r) hi_lane = OFFW'(BYTES - 1);
        req       = mem_r | (|mem_w);
        accept    = req & ~mem_busy;
        conflict  = mem_r & (|mem_w);
        last_byte = {1'b0, mem_addr} + (XLEN+1)'(hi_lane);
        oor       = last_byte >= (XLEN+1)'(LIMIT_B);
        split     = mem_r ? (off != '0)
                          : (({1'b0, off} + {1'b0, hi_lane}) >= (OFFW+1)'(BYTES));
        split_go  = accept & ~conflict & split;
        // Lanes rotated into place across the two words N and N+1
        wdata_sh  = {{XLEN{1'b0}}, mem_din} << {off, 3'b000};
        wstrb_sh  = {{BYTES{1'b0}}, mem_w} << off;
        // Bytes at addr+i gathered from word N (captured) and word N+1 (read now)
        split_rdata = XLEN'({hi_word, hold_rdata_q} >> {hold_off_q, 3'b000});
    end

    // FSM state register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state: SPLIT always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (split_go) state_d = StSplit;
            StSplit: state_d = StIdle;
        endcase
    end

    // FSM and pipeline outputs
    always_comb begin
        mem_busy   = (state_q == StSplit);
        mem_rvalid = pipe_valid_q[READ_LAT-1];
        mem_dout   = pipe_data_q[READ_LAT-1];
        mem_err    = err_q;
    end

    // Capture the second-beat context of a split access
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            hold_word_q    <= '0;
            hold_wdata_q   <= '0;
            hold_wstrb_q   <= '0;
            hold_rdata_q   <= '0;
            hold_off_q     <= '0;
            hold_is_read_q <= 1'b0;
            hold_err_q     <= 1'b0;
        end else if (split_go) begin
            hold_word_q    <= word_idx + AW'(1);
            hold_wdata_q   <= wdata_sh[2*XLEN-1:XLEN];
            hold_wstrb_q   <= oor ? '0 : wstrb_sh[2*BYTES-1:BYTES];
            hold_rdata_q   <= rd_word;
            hold_off_q     <= off;
            hold_is_read_q <= mem_r;
            hold_err_q     <= oor;
        end
    end

    // Select which beat drives the array write port this cycle
    always_comb begin
        wr_en   = '0;
        wr_idx  = word_idx;
        wr_data = wdata_sh[XLEN-1:0];
        if (state_q == StSplit) begin
            wr_en   = hold_wstrb_q;
            wr_idx  = hold_word_q;
            wr_data = hold_wdata_q;
        end else if (accept && !mem_r && !oor) begin
            wr_en = wstrb_sh[BYTES-1:0];
        end
    end

    // Byte-lane array write; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (wr_en[i]) mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
    end

    // Read result entering the pipeline; out-of-range reads return zero
    always_comb begin
        push_valid = 1'b0;
        push_data  = '0;
        if (state_q == StSplit) begin
            if (hold_is_read_q) begin
                push_valid = 1'b1;
                push_data  = hold_err_q ? '0 : split_rdata;
            end
        end else if (accept && mem_r && !conflict && !split) begin
            push_valid = 1'b1;
            push_data  = oor ? '0 : rd_word;
        end
    end

    // Read latency pipeline; data is zero whenever its valid is low
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int k = 0; k < READ_LAT; k++) begin
                pipe_valid_q[k] <= 1'b0;
                pipe_data_q[k]  <= '0;
            end
        end else begin
            pipe_valid_q[0] <= push_valid;
            pipe_data_q[0]  <= push_data;
            for (int k = 1; k < READ_LAT; k++) begin
                pipe_valid_q[k] <= pipe_valid_q[k-1];
                pipe_data_q[k]  <= pipe_data_q[k-1];
            end
        end
    end

    // One-cycle error pulse after a rejected request
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) err_q <= 1'b0;
        else        err_q <= accept & (conflict | oor);
    end

endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: scoreboard bench driving two mem_port instances (READ_LAT 1 and 3)
// with identical stimulus and checking reads, timing, busy and error pulses.
module tb_mem_port;

    localparam int DEPTH = 64;
    localparam int LIMIT = DEPTH * 4;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_r = 1'b0;
    logic [3:0]  mem_w = '0;
    logic [31:0] mem_din = '0;

    logic [31:0] dout [2];
    logic        rv   [2];
    logic        busy [2];
    logic        err  [2];

    exp_t        sbq [2][$];
    logic [7:0]  model [LIMIT];
    int          cyc = 0;
    int          err_cyc = -1;
    int          busy_cyc = -1;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_port #(.XLEN(32), .DEPTH_WORDS(DEPTH), .READ_LAT(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w),
        .mem_din(mem_din), .mem_dout(dout[0]), .mem_rvalid(rv[0]), .mem_busy(busy[0]),
        .mem_err(err[0])
    );

    mem_port #(.XLEN(32), .DEPTH_WORDS(DEPTH), .READ_LAT(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w),
        .mem_din(mem_din), .mem_dout(dout[1]), .mem_rvalid(rv[1]), .mem_busy(busy[1]),
        .mem_err(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_rd(input int a);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (a + i < LIMIT) r[i*8 +: 8] = model[a+i];
        end
        return r;
    endfunction

    // Drive one request for one cycle (called #1 after a rising edge) and push expectations.
    task automatic issue(input int a, input logic r, input logic [3:0] w, input logic [31:0] d);
        int          k, off, hi, lat;
        logic        conflict, oor, split;
        logic [31:0] rd;
        exp_t        e;
        k = cyc;
        off = a % 4;
        hi = 0;
        for (int i = 0; i < 4; i++) if (w[i]) hi = i;
        if (r) hi = 3;
        conflict = r && (w != 4'b0);
        oor = (a + hi) >= LIMIT;
        split = r ? (off != 0) : (off + hi >= 4);
        if (conflict) begin
            err_cyc = k + 1;
            split = 1'b0;
        end else begin
            if (oor) err_cyc = k + 1;
            if (split) busy_cyc = k + 1;
            if (r) begin
                rd = oor ? 32'h0 : model_rd(a);
                for (int dd = 0; dd < 2; dd++) begin
                    lat = (dd == 0) ? 1 : 3;
                    e.data = rd;
                    e.cyc = k + lat + (split ? 1 : 0);
                    sbq[dd].push_back(e);
                end
            end else if (!oor) begin
                for (int i = 0; i < 4; i++) if (w[i]) model[a+i] = d[i*8 +: 8];
            end
        end
        mem_addr = 32'(a);
        mem_r = r;
        mem_w = w;
        mem_din = d;
        @(posedge clk);
        #1;
        mem_r = 1'b0;
        mem_w = 4'b0;
        if (split) begin
            // A read presented while busy must be ignored
            mem_addr = 32'h0;
            mem_r = 1'b1;
            @(posedge clk);
            #1;
            mem_r = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor: error/busy pulses, scoreboard pops, idle data
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("err[%0d]", d), 32'(err[d]), 32'((cyc == err_cyc) && !resetn));
            check($sformatf("busy[%0d]", d), 32'(busy[d]), 32'((cyc == busy_cyc) && !resetn));
            if (rv[d]) begin
                if (sbq[d].size() == 0) begin
                    check($sformatf("rv_unexpected[%0d]", d), 32'(sbq[d].size()), 32'd1);
                end else begin
                    e = sbq[d].pop_front();
                    check($sformatf("rv_cycle[%0d]", d), 32'(cyc), 32'(e.cyc));
                    check($sformatf("rdata[%0d]", d), dout[d], e.data);
                end
            end else begin
                check($sformatf("dout_idle[%0d]", d), dout[d], 32'h0);
                if (sbq[d].size() > 0 && sbq[d][0].cyc <= cyc) begin
                    check($sformatf("rv_missing[%0d]", d), 32'(rv[d]), 32'd1);
                    void'(sbq[d].pop_front());
                end
            end
        end
    end

    initial begin
        #1 resetn = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_rvalid[%0d]", d), 32'(rv[d]), 32'd0);
            check($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'd0);
            check($sformatf("rst_err[%0d]", d), 32'(err[d]), 32'd0);
            check($sformatf("rst_dout[%0d]", d), dout[d], 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        idle(1);

        // Preload the whole array with zeros
        for (int wd = 0; wd < DEPTH; wd++) issue(wd * 4, 1'b0, 4'hF, 32'h0);

        // Byte round-trip
        issue(0, 1'b0, 4'b0001, 32'h0000_0084);
        issue(0, 1'b0, 4'b0010, 32'h0000_E800);
        issue(0, 1'b1, 4'b0000, 32'h0);
        idle(4);

        // Misaligned word write, then reads around it
        issue(2, 1'b0, 4'b1111, 32'hDDCC_BBAA);
        issue(0, 1'b1, 4'b0000, 32'h0);
        issue(4, 1'b1, 4'b0000, 32'h0);
        issue(2, 1'b1, 4'b0000, 32'h0);
        idle(5);

        // Back-to-back pipelined reads
        issue(0, 1'b0, 4'hF, 32'd1);
        issue(4, 1'b0, 4'hF, 32'd2);
        issue(8, 1'b0, 4'hF, 32'd3);
        issue(0, 1'b1, 4'h0, 32'h0);
        issue(4, 1'b1, 4'h0, 32'h0);
        issue(8, 1'b1, 4'h0, 32'h0);
        idle(6);

        // Error cases and range boundaries
        issue(LIMIT, 1'b0, 4'hF, 32'h1234_5678);
        idle(2);
        issue(0, 1'b1, 4'b0001, 32'h0000_00FF);
        idle(2);
        issue(LIMIT, 1'b1, 4'h0, 32'h0);
        idle(2);
        issue(LIMIT - 1, 1'b0, 4'b0001, 32'h0000_005A);
        issue(LIMIT - 4, 1'b1, 4'h0, 32'h0);
        issue(0, 1'b1, 4'h0, 32'h0);
        idle(6);

        // Reset in the middle of a split read
        mem_addr = 32'd1;
        mem_r = 1'b1;
        busy_cyc = cyc + 1;
        @(posedge clk);
        #1;
        mem_addr = 32'd8;
        check("split_busy", 32'(busy[0]), 32'd1);
        #1 resetn = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_busy[%0d]", d), 32'(busy[d]), 32'd0);
            check($sformatf("midrst_rvalid[%0d]", d), 32'(rv[d]), 32'd0);
            check($sformatf("midrst_dout[%0d]", d), dout[d], 32'd0);
        end
        mem_r = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        busy_cyc = -1;
        idle(6);

        // Reset in the middle of a split write: only the first beat lands
        mem_addr = 32'd3;
        mem_w = 4'b0011;
        mem_din = 32'h0000_2211;
        busy_cyc = cyc + 1;
        model[3] = 8'h11;
        @(posedge clk);
        #1;
        mem_w = 4'b0;
        check("splitw_busy", 32'(busy[1]), 32'd1);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1 resetn = 1'b0;
        busy_cyc = -1;
        idle(1);
        issue(0, 1'b1, 4'h0, 32'h0);
        issue(4, 1'b1, 4'h0, 32'h0);
        idle(8);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("sb_drained[%0d]", d), 32'(sbq[d].size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
